// File: rtl/wallace_arb_pkg.sv
// Shared constants and FSM encoding for the wallace_mult_arbiter block.
// Optional statistics counters are enabled by defining WALLACE_ARB_STATS_EN.
package wallace_arb_pkg;

   localparam int OPW   = 8;
   localparam int PRODW = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/Wallace_Tree_Multiplier.sv
// Unsigned 8x8 combinational multiplier: partial products reduced by a
// carry-save (3:2) tree down to two words, then one final carry-propagate add.
module Wallace_Tree_Multiplier
   import wallace_arb_pkg::*;
(
   input  logic [OPW-1:0]   a,
   input  logic [OPW-1:0]   b,
   output logic [PRODW-1:0] p
);

   logic [PRODW-1:0] pp [OPW];

   // {carry, sum}; carry is pre-shifted so both words share the same weight
   function automatic logic [2*PRODW-1:0] csa(input logic [PRODW-1:0] x,
                                              input logic [PRODW-1:0] y,
                                              input logic [PRODW-1:0] z);
      logic [PRODW-1:0] s;
      logic [PRODW-1:0] c;
      s = x ^ y ^ z;
      c = ((x & y) | (x & z) | (y & z)) << 1;
      return {c, s};
   endfunction

   always_comb begin
      for (int i = 0; i < OPW; i++) begin
         pp[i] = b[i] ? (PRODW'(a) << i) : '0;
      end
   end

   logic [2*PRODW-1:0] l1a, l1b, l2a, l2b, l3, l4;

   assign l1a = csa(pp[0], pp[1], pp[2]);
   assign l1b = csa(pp[3], pp[4], pp[5]);
   assign l2a = csa(l1a[PRODW-1:0], l1a[2*PRODW-1:PRODW], l1b[PRODW-1:0]);
   assign l2b = csa(l1b[2*PRODW-1:PRODW], pp[6], pp[7]);
   assign l3  = csa(l2a[PRODW-1:0], l2a[2*PRODW-1:PRODW], l2b[PRODW-1:0]);
   assign l4  = csa(l3[PRODW-1:0], l3[2*PRODW-1:PRODW], l2b[2*PRODW-1:PRODW]);

   assign p = l4[PRODW-1:0] + l4[2*PRODW-1:PRODW];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the requester after the last
// winner; the pointer advances only when a grant is actually issued.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx
);

   logic [ID_W-1:0] ptr;
   logic            found;

   function automatic logic [ID_W-1:0] wrap(input int v);
      if (v >= NUM_REQ) return ID_W'(v - NUM_REQ);
      return ID_W'(v);
   endfunction

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[wrap(int'(ptr) + k)]) begin
            found = 1'b1;
            idx   = wrap(int'(ptr) + k);
         end
      end
   end

   assign grant = (en && found) ? (NUM_REQ'(1) << idx) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (en && found) begin
         ptr <= wrap(int'(idx) + 1);
      end
   end

endmodule

// File: rtl/wallace_mult_arbiter.sv
// Shares one registered Wallace multiplier among NUM_REQ valid/ready clients.
// Define WALLACE_ARB_STATS_EN to add the stat_ops / stat_stall counters.
module wallace_mult_arbiter
   import wallace_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*OPW-1:0] req_a,
   input  logic [NUM_REQ*OPW-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [PRODW-1:0]       rsp_product,
   output logic                   busy
`ifdef WALLACE_ARB_STATS_EN
   ,
   output logic [31:0]            stat_ops,
   output logic [31:0]            stat_stall
`endif
);

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // a requester holds valid and operands until ready, the response is held
   // stable until rsp_ready.

   state_t               state;
   logic [OPW-1:0]       op_a;
   logic [OPW-1:0]       op_b;
   logic [ID_W-1:0]      id_q;
   logic [PRODW-1:0]     mult_p;
   logic                 arb_en;
   logic [NUM_REQ-1:0]   grant;
   logic [ID_W-1:0]      grant_idx;

   // New work is only accepted when the response slot is free or draining now
   assign arb_en    = rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
   assign req_ready = grant;
   assign busy      = (state != IDLE);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (arb_en),
      .req   (req_valid),
      .grant (grant),
      .idx   (grant_idx)
   );

   (* DONT_TOUCH = "yes" *)
   Wallace_Tree_Multiplier u_mult (
      .a (op_a),
      .b (op_b),
      .p (mult_p)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         op_a        <= '0;
         op_b        <= '0;
         id_q        <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  op_a  <= req_a[OPW*grant_idx +: OPW];
                  op_b  <= req_b[OPW*grant_idx +: OPW];
                  id_q  <= grant_idx;
                  state <= EXEC;
               end
            end
            EXEC: begin
               rsp_product <= mult_p;
               rsp_id      <= id_q;
               rsp_valid   <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (|grant) begin
                     op_a  <= req_a[OPW*grant_idx +: OPW];
                     op_b  <= req_b[OPW*grant_idx +: OPW];
                     id_q  <= grant_idx;
                     state <= EXEC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WALLACE_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_ops   <= '0;
         stat_stall <= '0;
      end else begin
         if (rsp_valid && rsp_ready && (stat_ops != '1)) begin
            stat_ops <= stat_ops + 32'd1;
         end
         if ((state == RESP) && !rsp_ready && (stat_stall != '1)) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Scoreboard bench for wallace_mult_arbiter: a transaction-level model predicts
// grants and queues expected {id, product}; a monitor pops on each handshake.
module tb_wallace_mult_arbiter;

   localparam int N    = 4;
   localparam int ID_W = 2;
   localparam int W    = ID_W + 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_ready;
   logic [N*8-1:0]   req_a;
   logic [N*8-1:0]   req_b;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [ID_W-1:0]  rsp_id;
   logic [15:0]      rsp_product;
   logic             busy;
`ifdef WALLACE_ARB_STATS_EN
   logic [31:0]      stat_ops;
   logic [31:0]      stat_stall;
`endif

   logic [7:0]       a_v [N];
   logic [7:0]       b_v [N];
   logic [N-1:0]     cont = '0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] rsp_log[$];
   int           rsp_cyc[$];

   // transaction-level reference state
   int           m_ptr  = 0;
   bit           m_exec = 0;
   bit           m_resp = 0;
   logic [N-1:0] m_gnt  = '0;
   int           m_ops  = 0;
   int           m_stall = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_a[i*8 +: 8] = a_v[i];
         req_b[i*8 +: 8] = b_v[i];
      end
   end

   wallace_mult_arbiter #(.NUM_REQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .busy        (busy)
`ifdef WALLACE_ARB_STATS_EN
      ,
      .stat_ops    (stat_ops),
      .stat_stall  (stat_stall)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one step per cycle, evaluated mid-cycle on stable inputs
   always @(negedge clk) begin : model
      logic [N-1:0] exp_rdy;
      int           win;
      if (!rst) begin
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         m_ptr = 0; m_exec = 0; m_resp = 0; m_gnt = '0;
         m_ops = 0; m_stall = 0;
         exp_q.delete();
      end else begin
         exp_rdy = '0;
         win = -1;
         if (!m_exec && (!m_resp || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
               if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
         end
         if (win >= 0) exp_rdy[win] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
         chk("busy", 32'(busy), 32'(m_exec || m_resp));
         if (m_resp && rsp_ready)  m_ops++;
         if (m_resp && !rsp_ready) m_stall++;
         m_resp = m_exec ? 1'b1 : (m_resp && !rsp_ready);
         if (win >= 0) begin
            exp_q.push_back({ID_W'(win), 16'(a_v[win]) * 16'(b_v[win])});
            m_ptr = (win + 1) % N;
         end
         m_exec = (win >= 0);
         m_gnt  = exp_rdy;
      end
   end

   // Monitor: pops on every response handshake, checks stability under stall
   always @(negedge clk) begin : monitor
      static bit          held = 0;
      static logic [ID_W-1:0] h_id = '0;
      static logic [15:0] h_prod = '0;
      logic [W-1:0]       e;
      if (!rst) begin
         held = 0;
      end else begin
         if (held) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_id", 32'(rsp_id), 32'(h_id));
            chk("hold_product", 32'(rsp_product), 32'(h_prod));
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp actual_id=%0d actual_product=%0h expected=none", rsp_id, rsp_product);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id", 32'(rsp_id), 32'(e[W-1:16]));
               chk("rsp_product", 32'(rsp_product), 32'(e[15:0]));
            end
            rsp_log.push_back({rsp_id, rsp_product});
            rsp_cyc.push_back(cyc);
         end
         held   = rsp_valid && !rsp_ready;
         h_id   = rsp_id;
         h_prod = rsp_product;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (m_gnt[i] && !cont[i]) req_valid[i] = 1'b0;
      end
   endtask

   task automatic request(input int i, input logic [7:0] a, input logic [7:0] b);
      a_v[i] = a;
      b_v[i] = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_rsp(input string name);
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      if (!rsp_valid) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_rsp_valid expected=rsp_valid", name);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0]  ba [3];
      logic [7:0]  bb [3];
      logic [15:0] bp [3];
      int          bid [3];
      logic [W-1:0] ent;
      int          n;
      int          id1_cnt;
`ifdef WALLACE_ARB_STATS_EN
      logic [31:0] s0;
`endif
      ba = '{8'h00, 8'h80, 8'h01};
      bb = '{8'hAB, 8'h02, 8'hFF};
      bp = '{16'h0000, 16'h0100, 16'h00FF};
      bid = '{0, 1, 3};
      for (int i = 0; i < N; i++) begin
         a_v[i] = 8'($urandom_range(255));
         b_v[i] = 8'($urandom_range(255));
      end

      // reset with every requester asking: nothing may be granted
      #2 rst = 1'b0;
      req_valid = '1;
      repeat (3) tick();
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_product", 32'(rsp_product), 32'd0);
      req_valid = '0;
      rst = 1'b1;
      tick();

      // single requester, 0xFF*0xFF, two-cycle latency
      request(2, 8'hFF, 8'hFF);
      tick();
      chk("single_exec_ready", 32'(req_ready), 32'd0);
      chk("single_exec_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("single_valid", 32'(rsp_valid), 32'd1);
      chk("single_product", 32'(rsp_product), 32'hFE01);
      chk("single_id", 32'(rsp_id), 32'd2);
      repeat (2) tick();

      // all requesters continuously valid: fair rotation, one product per 2 cycles
      apply_reset();
      rsp_log.delete();
      rsp_cyc.delete();
      cont = '1;
      for (int i = 0; i < N; i++) request(i, 8'(i + 1), 8'h10);
      n = 0;
      while (rsp_log.size() < 5 && n < 40) begin
         tick();
         n++;
      end
      cont = '0;
      req_valid = '0;
      repeat (6) tick();
      if (rsp_log.size() < 5) begin
         checks++;
         errors++;
         $display("FAIL rr_count actual=%0d expected=5", rsp_log.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            ent = rsp_log[k];
            chk("rr_order_id", 32'(ent[W-1:16]), 32'(k % N));
            chk("rr_order_product", 32'(ent[15:0]), 32'(16'h10 * ((k % N) + 1)));
         end
         for (int k = 0; k < 4; k++) begin
            chk("rr_spacing", 32'(rsp_cyc[k + 1] - rsp_cyc[k]), 32'd2);
         end
      end

      // backpressure: response held five cycles, no new grant meanwhile
      rsp_ready = 1'b0;
      request(1, 8'h37, 8'h5A);
      wait_rsp("bp");
      request(3, 8'h11, 8'h22);
`ifdef WALLACE_ARB_STATS_EN
      s0 = stat_stall;
`endif
      repeat (5) begin
         tick();
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_product", 32'(rsp_product), 32'h1356);
         chk("bp_id", 32'(rsp_id), 32'd1);
      end
`ifdef WALLACE_ARB_STATS_EN
      chk("bp_stat_stall", stat_stall - s0, 32'd5);
`endif
      rsp_ready = 1'b1;
      repeat (6) tick();

      // boundary operands
      for (int k = 0; k < 3; k++) begin
         request(bid[k], ba[k], bb[k]);
         wait_rsp("boundary");
         chk("boundary_product", 32'(rsp_product), 32'(bp[k]));
         chk("boundary_id", 32'(rsp_id), 32'(bid[k]));
         tick();
      end
      tick();

      // reset while the multiplier is in flight
      request(2, 8'h05, 8'h06);
      tick();
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      request(3, 8'h07, 8'h08);
      request(0, 8'h03, 8'h04);
      rst = 1'b1;
      wait_rsp("post_rst");
      chk("post_rst_id", 32'(rsp_id), 32'd0);
      chk("post_rst_product", 32'(rsp_product), 32'd12);
      repeat (6) tick();

      // withdrawn request while the response is stalled
      rsp_log.delete();
      rsp_ready = 1'b0;
      request(0, 8'h09, 8'h09);
      wait_rsp("wd");
      request(1, 8'h44, 8'h55);
      tick();
      req_valid[1] = 1'b0;
      repeat (2) tick();
      rsp_ready = 1'b1;
      repeat (6) tick();
      id1_cnt = 0;
      foreach (rsp_log[k]) begin
         ent = rsp_log[k];
         if (ent[W-1:16] == ID_W'(1)) id1_cnt++;
      end
      chk("withdrawn_id1_rsps", 32'(id1_cnt), 32'd0);
      chk("withdrawn_rsp_count", 32'(rsp_log.size()), 32'd1);

      // randomized traffic with random backpressure
      repeat (400) begin
         rsp_ready = ($urandom_range(3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(2) == 0) begin
               request(i, 8'($urandom_range(255)), 8'($urandom_range(255)));
            end
         end
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (10) tick();
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef WALLACE_ARB_STATS_EN
      chk("stat_ops", stat_ops, 32'(m_ops));
      chk("stat_stall", stat_stall, 32'(m_stall));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
